// File: rtl/neuron_layer_collector.sv
// Collects single-cycle MAC result pulses into a layer vector, tracks the signed max/argmax,
// and presents each completed vector over a valid/ready handshake.
module neuron_layer_collector #(
  parameter int NUM_NEURONS = 4,
  parameter int OUT_W       = 16,
  parameter int IDX_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [OUT_W-1:0]             in_data,
  output logic                         accept_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_NEURONS*OUT_W-1:0] out_vec,
  output logic [OUT_W-1:0]             out_max,
  output logic [IDX_W-1:0]             out_argmax,
  output logic [IDX_W:0]               count,
  output logic                         overflow
);

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_NEURONS - 1);

  state_t             state_reg, state_next;
  logic [IDX_W:0]     count_reg;
  logic [OUT_W-1:0]   max_reg;
  logic [IDX_W-1:0]   argmax_reg;
  logic               overflow_reg;
  logic [OUT_W-1:0]   vec_reg [NUM_NEURONS];

  logic accept;
  logic drop;
  logic last_sample;
  logic new_max;

  // In PRESENT a sample is only taken when the held vector leaves in the same cycle.
  assign accept      = in_valid && ((state_reg == COLLECT) || out_ready);
  assign drop        = in_valid && (state_reg == PRESENT) && !out_ready;
  assign last_sample = (count_reg == LAST);
  assign new_max     = (count_reg == '0) || ($signed(in_data) > $signed(max_reg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= COLLECT;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear)
      state_next = COLLECT;
    else if (accept && last_sample)
      state_next = PRESENT;
    else if (state_reg == PRESENT && out_ready)
      state_next = COLLECT;
  end

  always_comb begin
    accept_ready = (state_reg == COLLECT);
    out_valid    = (state_reg == PRESENT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      max_reg      <= '0;
      argmax_reg   <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        count_reg <= last_sample ? '0 : count_reg + 1'b1;
        if (new_max) begin
          max_reg    <= in_data;
          argmax_reg <= count_reg[IDX_W-1:0];
        end
      end
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          vec_reg[gi] <= '0;
        else if (!clear && accept && count_reg == (IDX_W+1)'(gi))
          vec_reg[gi] <= in_data;
      end
      assign out_vec[gi*OUT_W +: OUT_W] = vec_reg[gi];
    end
  endgenerate

  assign out_max    = max_reg;
  assign out_argmax = argmax_reg;
  assign count      = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_neuron_layer_collector.sv
// Directed bench for neuron_layer_collector: a 4-neuron instance and a 1-neuron instance.
module tb_neuron_layer_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        accept_ready, out_valid, overflow;
  logic [63:0] out_vec;
  logic [15:0] out_max;
  logic [1:0]  out_argmax;
  logic [2:0]  count;

  logic        in_valid1 = 1'b0;
  logic [15:0] in_data1 = '0;
  logic        out_ready1 = 1'b1;
  logic        accept_ready1, out_valid1, overflow1;
  logic [15:0] out_vec1, out_max1;
  logic [0:0]  out_argmax1;
  logic [1:0]  count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_layer_collector #(.NUM_NEURONS(4), .OUT_W(16), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .accept_ready(accept_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_max(out_max), .out_argmax(out_argmax),
    .count(count), .overflow(overflow)
  );

  neuron_layer_collector #(.NUM_NEURONS(1), .OUT_W(16), .IDX_W(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid1), .in_data(in_data1),
    .accept_ready(accept_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_vec(out_vec1), .out_max(out_max1), .out_argmax(out_argmax1),
    .count(count1), .overflow(overflow1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Inputs change on the falling edge; the next falling edge sees the registered result.
  task automatic step(input logic v, input logic [15:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_val("rst_accept_ready", accept_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_count", count, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_out_vec", out_vec, 0);
    check_val("rst_out_max", out_max, 0);
    check_val("rst_out_argmax", out_argmax, 0);
    check_val("rst1_out_valid", out_valid1, 0);

    // 1: basic vector
    step(1, 16'd10, 0);
    step(1, 16'hFFFD, 0);
    check_val("t1_count_mid", count, 2);
    step(1, 16'd25, 0);
    check_val("t1_valid_before_last", out_valid, 0);
    step(1, 16'd7, 0);
    check_val("t1_out_valid", out_valid, 1);
    check_val("t1_accept_ready", accept_ready, 0);
    check_val("t1_out_vec", out_vec, 64'h0007_0019_FFFD_000A);
    check_val("t1_out_max", out_max, 16'd25);
    check_val("t1_out_argmax", out_argmax, 2);
    check_val("t1_count_wrap", count, 0);
    step(0, 0, 1);
    check_val("t1_hs_out_valid", out_valid, 0);
    check_val("t1_hs_accept_ready", accept_ready, 1);

    // 2: ties and negatives
    step(1, 16'hFFFB, 0);
    step(1, 16'hFFFB, 0);
    step(1, 16'hFFF7, 0);
    step(1, 16'hFFFB, 0);
    check_val("t2_out_valid", out_valid, 1);
    check_val("t2_out_vec", out_vec, 64'hFFFB_FFF7_FFFB_FFFB);
    check_val("t2_out_max", out_max, 16'hFFFB);
    check_val("t2_out_argmax", out_argmax, 0);
    step(0, 0, 1);
    check_val("t2_hs_count", count, 0);
    check_val("t2_hs_out_valid", out_valid, 0);

    // 3: backpressure and dropped pulse
    step(1, 16'd1, 0);
    step(1, 16'd2, 0);
    step(1, 16'd3, 0);
    step(1, 16'd4, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    check_val("t3_held_valid", out_valid, 1);
    check_val("t3_overflow_pre", overflow, 0);
    step(1, 16'd42, 0);
    check_val("t3_overflow_set", overflow, 1);
    check_val("t3_vec_held", out_vec, 64'h0004_0003_0002_0001);
    check_val("t3_max_held", out_max, 16'd4);
    check_val("t3_argmax_held", out_argmax, 3);
    check_val("t3_count_held", count, 0);
    step(0, 0, 0);
    check_val("t3_overflow_sticky", overflow, 1);
    step(0, 0, 1);
    check_val("t3_hs_out_valid", out_valid, 0);
    check_val("t3_hs_overflow", overflow, 1);
    step(0, 0, 0);
    check_val("t3_overflow_still", overflow, 1);
    clear = 1'b1;
    step(0, 0, 0);
    clear = 1'b0;
    check_val("t3_clear_overflow", overflow, 0);

    // 4: flow-through on handshake
    step(1, 16'd5, 0);
    step(1, 16'd6, 0);
    step(1, 16'd7, 0);
    step(1, 16'd8, 0);
    check_val("t4_held_max", out_max, 16'd8);
    step(1, 16'd99, 1);
    check_val("t4_ft_out_valid", out_valid, 0);
    check_val("t4_ft_count", count, 1);
    check_val("t4_ft_overflow", overflow, 0);
    check_val("t4_ft_slot0", out_vec[15:0], 16'd99);
    check_val("t4_ft_max", out_max, 16'd99);
    step(1, 16'd1, 0);
    step(1, 16'd2, 0);
    check_val("t4_not_yet", out_valid, 0);
    step(1, 16'd3, 0);
    check_val("t4_out_valid", out_valid, 1);
    check_val("t4_out_vec", out_vec, 64'h0003_0002_0001_0063);
    check_val("t4_out_max", out_max, 16'd99);
    check_val("t4_out_argmax", out_argmax, 0);
    step(0, 0, 1);

    // 5a: asynchronous reset mid-vector
    step(1, 16'd11, 0);
    step(1, 16'd12, 0);
    check_val("t5_count_mid", count, 2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("t5_rst_count", count, 0);
    check_val("t5_rst_vec", out_vec, 0);
    check_val("t5_rst_max", out_max, 0);
    check_val("t5_rst_accept", accept_ready, 1);
    #1 rst = 1'b0;
    @(negedge clk);

    // 5b: clear with simultaneous pulse
    step(1, 16'd21, 0);
    step(1, 16'd22, 0);
    check_val("t5_count_mid2", count, 2);
    clear = 1'b1;
    step(1, 16'd77, 0);
    clear = 1'b0;
    check_val("t5_clear_count", count, 0);
    check_val("t5_clear_valid", out_valid, 0);
    check_val("t5_clear_slot2", out_vec[47:32], 16'd0);
    step(1, 16'hFFF0, 0);
    check_val("t5_post_count", count, 1);
    check_val("t5_post_slot0", out_vec[15:0], 16'hFFF0);
    check_val("t5_post_max", out_max, 16'hFFF0);
    step(0, 0, 0);

    // 6: single-neuron build
    check_val("t6_idle_valid", out_valid1, 0);
    in_valid1 = 1'b1;
    in_data1  = 16'd3;
    @(negedge clk);
    check_val("t6_v1_valid", out_valid1, 1);
    check_val("t6_v1_max", out_max1, 16'd3);
    check_val("t6_v1_argmax", out_argmax1, 0);
    check_val("t6_v1_vec", out_vec1, 16'd3);
    in_data1 = 16'hFFFF;
    @(negedge clk);
    check_val("t6_v2_valid", out_valid1, 1);
    check_val("t6_v2_max", out_max1, 16'hFFFF);
    check_val("t6_v2_argmax", out_argmax1, 0);
    check_val("t6_v2_overflow", overflow1, 0);
    in_valid1 = 1'b0;
    @(negedge clk);
    check_val("t6_done_valid", out_valid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
